// File: rtl/ql_episode_ctrl.sv
// Episode sequencer for the Q-learning update datapath. Each step reads Q(cur), picks an
// action epsilon-greedily, asks the environment for the next state, forms gamma*maxQ(next)
// and issues a one-hot update.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | load start_state, clear step count
// RD_CUR | present cur to datapath, capture Q0..Q3 after DP_LAT
// SELECT | advance LFSR, choose action
// ENV    | env_req until env_ack, latch next state
// RD_NXT | present next to datapath, register saturated gamma*maxQ
// UPD    | one-hot dp_u on cur for DP_LAT cycles
// ADV    | cur <= next, count step, decide episode / training end
// DONE   | one-cycle done pulse
module ql_episode_ctrl #(
    parameter int          STATE_W   = 6,
    parameter int          DP_LAT    = 2,
    parameter int          FRAC      = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [STATE_W-1:0] start_state,
    input  logic [STATE_W-1:0] goal_state,
    input  logic [23:0]        gamma,
    input  logic [7:0]         epsilon,
    input  logic [15:0]        max_steps,
    input  logic [15:0]        num_episodes,
    output logic               env_req,
    output logic [STATE_W-1:0] env_state_cur,
    output logic [1:0]         env_action,
    input  logic               env_ack,
    input  logic [STATE_W-1:0] env_next_state,
    output logic [STATE_W-1:0] dp_state,
    output logic [3:0]         dp_u,
    input  logic [23:0]        dp_Q0,
    input  logic [23:0]        dp_Q1,
    input  logic [23:0]        dp_Q2,
    input  logic [23:0]        dp_Q3,
    input  logic [23:0]        dp_maxQ,
    output logic [23:0]        gamma_maxQ,
    output logic               busy,
    output logic               done,
    output logic [15:0]        step_cnt,
    output logic [15:0]        episode_cnt
);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_CUR, SELECT, ENV, RD_NXT, UPD, ADV, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [STATE_W-1:0]  cur_q, cur_d, nxt_q, nxt_d;
    logic [1:0]          act_q, act_d;
    logic [7:0]          lat_q, lat_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic signed [23:0]  qv_q [4];
    logic signed [23:0]  qv_d [4];
    logic [23:0]         gmq_q, gmq_d;
    logic                busy_q, busy_d;
    logic [15:0]         step_q, step_d, ep_q, ep_d;

    logic [15:0]         lfsr_adv;
    logic [1:0]          best_idx;
    logic signed [23:0]  best_val;
    logic signed [47:0]  prod, scaled;
    logic [23:0]         sat_val;
    logic [15:0]         step_inc, step_lim, ep_inc;
    logic                ep_end;

    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign step_inc = step_q + 16'd1;
    assign step_lim = (max_steps == 16'd0) ? 16'd1 : max_steps;
    assign ep_inc   = ep_q + 16'd1;
    assign ep_end   = (nxt_q == goal_state) || (step_inc >= step_lim);

    // Low 48 bits of the product are exact: |maxQ| < 2^23 and gamma < 2^24.
    assign prod    = $signed({{24{dp_maxQ[23]}}, dp_maxQ} * {24'd0, gamma});
    assign scaled  = prod >>> FRAC;
    assign sat_val = (scaled > 48'sh7FFFFF)                 ? 24'h7FFFFF :
                     (scaled < -48'sh800000)                ? 24'h800000 :
                                                              scaled[23:0];

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx = 2'd0;
        best_val = qv_q[0];
        for (int i = 1; i < 4; i++) begin
            if (qv_q[i] > best_val) begin
                best_val = qv_q[i];
                best_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        act_d    = act_q;
        lat_d    = lat_q;
        lfsr_d   = lfsr_q;
        qv_d     = qv_q;
        gmq_d    = gmq_q;
        busy_d   = busy_q;
        step_d   = step_q;
        ep_d     = ep_q;
        env_req  = 1'b0;
        dp_u     = 4'd0;
        dp_state = cur_q;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_episodes == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = INIT;
                        busy_d  = 1'b1;
                        ep_d    = 16'd0;
                    end
                end
            end
            INIT: begin
                cur_d   = start_state;
                step_d  = 16'd0;
                lat_d   = 8'(DP_LAT);
                state_d = RD_CUR;
            end
            RD_CUR: begin
                if (lat_q == 8'd0) begin
                    qv_d[0] = dp_Q0;
                    qv_d[1] = dp_Q1;
                    qv_d[2] = dp_Q2;
                    qv_d[3] = dp_Q3;
                    state_d = SELECT;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            SELECT: begin
                lfsr_d  = lfsr_adv;
                act_d   = (lfsr_adv[7:0] < epsilon) ? lfsr_adv[9:8] : best_idx;
                state_d = ENV;
            end
            ENV: begin
                env_req = 1'b1;
                if (env_ack) begin
                    nxt_d   = env_next_state;
                    lat_d   = 8'(DP_LAT);
                    state_d = RD_NXT;
                end
            end
            RD_NXT: begin
                dp_state = nxt_q;
                if (lat_q == 8'd0) begin
                    gmq_d   = sat_val;
                    lat_d   = 8'(DP_LAT - 1);
                    state_d = UPD;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            UPD: begin
                dp_u = 4'b0001 << act_q;
                if (lat_q == 8'd0) begin
                    state_d = ADV;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ADV: begin
                cur_d  = nxt_q;
                step_d = step_inc;
                if (ep_end) begin
                    ep_d    = ep_inc;
                    state_d = (ep_inc == num_episodes) ? DONE : INIT;
                end else begin
                    lat_d   = 8'(DP_LAT);
                    state_d = RD_CUR;
                end
            end
            DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            act_q   <= 2'd0;
            lat_q   <= 8'd0;
            lfsr_q  <= LFSR_SEED;
            for (int i = 0; i < 4; i++) qv_q[i] <= '0;
            gmq_q   <= 24'd0;
            busy_q  <= 1'b0;
            step_q  <= 16'd0;
            ep_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            act_q   <= act_d;
            lat_q   <= lat_d;
            lfsr_q  <= lfsr_d;
            qv_q    <= qv_d;
            gmq_q   <= gmq_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            ep_q    <= ep_d;
        end
    end

    assign env_state_cur = cur_q;
    assign env_action    = act_q;
    assign gamma_maxQ    = gmq_q;
    assign busy          = busy_q;
    assign step_cnt      = step_q;
    assign episode_cnt   = ep_q;

endmodule

// File: tb/tb_ql_episode_ctrl.sv
// Directed bench for ql_episode_ctrl: table-driven datapath, scripted environment responder.
module tb_ql_episode_ctrl;
    localparam int STATE_W = 6;
    localparam int DP_LAT  = 2;

    logic               CLK, RST, start;
    logic [STATE_W-1:0] start_state, goal_state;
    logic [23:0]        gamma;
    logic [7:0]         epsilon;
    logic [15:0]        max_steps, num_episodes;
    logic               env_req, env_ack;
    logic [STATE_W-1:0] env_state_cur, env_next_state, dp_state;
    logic [1:0]         env_action;
    logic [3:0]         dp_u;
    logic [23:0]        dp_Q0, dp_Q1, dp_Q2, dp_Q3, dp_maxQ, gamma_maxQ;
    logic               busy, done;
    logic [15:0]        step_cnt, episode_cnt;

    logic [23:0] q_tab [64][4];
    logic [23:0] mq_tab [64];

    int                 checks = 0;
    int                 errors = 0;
    int                 ack_delay = 0;
    bit                 env_use_fixed = 0;
    logic [STATE_W-1:0] env_fixed = '0;

    ql_episode_ctrl #(.STATE_W(STATE_W), .DP_LAT(DP_LAT), .FRAC(16), .LFSR_SEED(16'hACE1)) dut (
        .CLK(CLK), .RST(RST), .start(start), .start_state(start_state), .goal_state(goal_state),
        .gamma(gamma), .epsilon(epsilon), .max_steps(max_steps), .num_episodes(num_episodes),
        .env_req(env_req), .env_state_cur(env_state_cur), .env_action(env_action),
        .env_ack(env_ack), .env_next_state(env_next_state), .dp_state(dp_state), .dp_u(dp_u),
        .dp_Q0(dp_Q0), .dp_Q1(dp_Q1), .dp_Q2(dp_Q2), .dp_Q3(dp_Q3), .dp_maxQ(dp_maxQ),
        .gamma_maxQ(gamma_maxQ), .busy(busy), .done(done), .step_cnt(step_cnt),
        .episode_cnt(episode_cnt)
    );

    assign dp_Q0   = q_tab[dp_state][0];
    assign dp_Q1   = q_tab[dp_state][1];
    assign dp_Q2   = q_tab[dp_state][2];
    assign dp_Q3   = q_tab[dp_state][3];
    assign dp_maxQ = mq_tab[dp_state];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment: acks after ack_delay extra cycles, next state is fixed or cur+1.
    initial begin
        int cnt;
        cnt = 0;
        env_ack = 1'b0;
        env_next_state = '0;
        forever begin
            @(negedge CLK);
            if (env_ack) begin
                env_ack = 1'b0;
                cnt = 0;
            end else if (env_req) begin
                cnt++;
                if (cnt > ack_delay) begin
                    env_ack = 1'b1;
                    env_next_state = env_use_fixed ? env_fixed : env_state_cur + 6'd1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick;
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_tabs;
        for (int s = 0; s < 64; s++) begin
            mq_tab[s] = 24'd0;
            for (int a = 0; a < 4; a++) q_tab[s][a] = 24'd0;
        end
    endtask

    task automatic start_run(input logic [5:0] ss, input logic [5:0] gs,
                             input logic [15:0] ms, input logic [15:0] ne);
        start_state = ss; goal_state = gs; max_steps = ms; num_episodes = ne;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (env_req === 1'b1) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic wait_upd(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (dp_u !== 4'd0) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (env_req !== 1'b0) begin errors++; $display("FAIL reset_env_req got %0b exp 0", env_req); end
        checks++; if (dp_u !== 4'd0) begin errors++; $display("FAIL reset_dp_u got %h exp 0", dp_u); end
        checks++; if (gamma_maxQ !== 24'd0) begin errors++; $display("FAIL reset_gmq got %h exp 0", gamma_maxQ); end
        checks++; if (step_cnt !== 16'd0 || episode_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", step_cnt, episode_cnt);
        end
        checks++; if (dp_state !== 6'd0 || env_state_cur !== 6'd0 || env_action !== 2'd0) begin
            errors++; $display("FAIL reset_state got %0d/%0d/%0d exp 0/0/0", dp_state, env_state_cur, env_action);
        end
    endtask

    task automatic test_greedy_discount;
        bit ok;
        int n;
        clear_tabs();
        q_tab[0][0] = 24'h050000; q_tab[0][1] = 24'h090000;
        q_tab[0][2] = 24'h090000; q_tab[0][3] = 24'hFD0000;
        mq_tab[1] = 24'h0A0000;
        gamma = 24'h00E666; epsilon = 8'd0; ack_delay = 0; env_use_fixed = 0;
        start_run(6'd0, 6'd1, 16'd5, 16'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL greedy_busy got %0b exp 1", busy); end
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL greedy_req_timeout got 0 exp 1"); end
        checks++; if (env_action !== 2'd1) begin errors++; $display("FAIL greedy_action got %0d exp 1", env_action); end
        checks++; if (env_state_cur !== 6'd0) begin errors++; $display("FAIL greedy_cur got %0d exp 0", env_state_cur); end
        wait_upd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL greedy_upd_timeout got 0 exp 1"); end
        checks++; if (gamma_maxQ !== 24'h08FFFC) begin errors++; $display("FAIL discount_0p9 got %h exp 08fffc", gamma_maxQ); end
        checks++; if (dp_state !== 6'd0) begin errors++; $display("FAIL upd_dp_state got %0d exp 0", dp_state); end
        n = 0;
        while (dp_u === 4'b0010 && n < 20) begin n++; tick(); end
        checks++; if (n != DP_LAT) begin errors++; $display("FAIL upd_len got %0d exp %0d", n, DP_LAT); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL greedy_done_timeout got 0 exp 1"); end
        checks++; if (episode_cnt !== 16'd1 || step_cnt !== 16'd1) begin
            errors++; $display("FAIL greedy_counts got %0d/%0d exp 1/1", episode_cnt, step_cnt);
        end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL greedy_after_done got busy %0b done %0b exp 0 0", busy, done);
        end
    endtask

    task automatic test_saturation;
        logic [23:0] mq  [3];
        logic [23:0] gm  [3];
        logic [23:0] exp_v [3];
        bit ok;
        mq[0] = 24'h7FFFFF; gm[0] = 24'h020000; exp_v[0] = 24'h7FFFFF;
        mq[1] = 24'h800000; gm[1] = 24'h020000; exp_v[1] = 24'h800000;
        mq[2] = 24'hFF0000; gm[2] = 24'h008000; exp_v[2] = 24'hFF8000;
        for (int v = 0; v < 3; v++) begin
            clear_tabs();
            mq_tab[5] = mq[v];
            gamma = gm[v]; epsilon = 8'd0; env_use_fixed = 1; env_fixed = 6'd5;
            start_run(6'd0, 6'd5, 16'd4, 16'd1);
            wait_upd(ok);
            checks++; if (!ok) begin errors++; $display("FAIL sat_upd_timeout vec %0d got 0 exp 1", v); end
            checks++; if (gamma_maxQ !== exp_v[v]) begin
                errors++; $display("FAIL sat_vec%0d got %h exp %h", v, gamma_maxQ, exp_v[v]);
            end
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout vec %0d got 0 exp 1", v); end
            tick();
        end
        env_use_fixed = 0;
    endtask

    task automatic test_episode_end;
        bit ok;
        clear_tabs();
        epsilon = 8'd0; ack_delay = 0; env_use_fixed = 0; gamma = 24'h010000;
        start_run(6'd0, 6'd3, 16'd100, 16'd2);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (episode_cnt === 16'd1) begin ok = 1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL ep_end_timeout got 0 exp 1"); end
        checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL ep_end_steps got %0d exp 3", step_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ep_end_busy got %0b exp 1", busy); end
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ep2_req_timeout got 0 exp 1"); end
        checks++; if (env_state_cur !== 6'd0 || step_cnt !== 16'd0) begin
            errors++; $display("FAIL ep2_restart got cur %0d steps %0d exp 0 0", env_state_cur, step_cnt);
        end
        checks++; if (env_action !== 2'd0) begin errors++; $display("FAIL ep2_action got %0d exp 0", env_action); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ep2_done_timeout got 0 exp 1"); end
        checks++; if (episode_cnt !== 16'd2 || step_cnt !== 16'd3) begin
            errors++; $display("FAIL ep2_counts got %0d/%0d exp 2/3", episode_cnt, step_cnt);
        end
        tick();
    endtask

    task automatic test_step_limit;
        int dones, reqs;
        bit prev_req;
        dones = 0; reqs = 0; prev_req = 0;
        clear_tabs();
        epsilon = 8'd0; ack_delay = 0; env_use_fixed = 0;
        start_run(6'd0, 6'd63, 16'd0, 16'd2);
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            if (done === 1'b1) dones++;
            if (env_req === 1'b1 && !prev_req) reqs++;
            prev_req = env_req;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL limit_busy got %0b exp 0", busy); end
        checks++; if (dones != 1) begin errors++; $display("FAIL limit_done_pulses got %0d exp 1", dones); end
        checks++; if (reqs != 2) begin errors++; $display("FAIL limit_steps_total got %0d exp 2", reqs); end
        checks++; if (episode_cnt !== 16'd2 || step_cnt !== 16'd1) begin
            errors++; $display("FAIL limit_counts got %0d/%0d exp 2/1", episode_cnt, step_cnt);
        end
        start_run(6'd0, 6'd63, 16'd4, 16'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_eps got done %0b busy %0b exp 1 0", done, busy);
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_eps_pulse got %0b exp 0", done); end
    endtask

    task automatic test_stall;
        bit ok;
        int n;
        logic [5:0] rec_cur;
        logic [1:0] rec_act;
        clear_tabs();
        q_tab[7][2] = 24'h010000;
        epsilon = 8'd0; ack_delay = 10; env_use_fixed = 0;
        start_run(6'd7, 6'd8, 16'd5, 16'd1);
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout got 0 exp 1"); end
        rec_cur = env_state_cur;
        rec_act = env_action;
        checks++; if (rec_cur !== 6'd7 || rec_act !== 2'd2) begin
            errors++; $display("FAIL stall_first got %0d/%0d exp 7/2", rec_cur, rec_act);
        end
        n = 0;
        while (env_req === 1'b1 && n < 40) begin
            checks++;
            if (env_state_cur !== rec_cur || env_action !== rec_act || dp_u !== 4'd0) begin
                errors++; $display("FAIL stall_stable cyc %0d got %0d/%0d/%h exp %0d/%0d/0",
                                   n, env_state_cur, env_action, dp_u, rec_cur, rec_act);
            end
            n++;
            tick();
        end
        checks++; if (n != 11) begin errors++; $display("FAIL stall_len got %0d exp 11", n); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got 0 exp 1"); end
        tick();
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_upd;
        bit ok;
        logic [15:0] lf;
        logic [1:0]  exp_a;
        clear_tabs();
        epsilon = 8'd0; ack_delay = 0; env_use_fixed = 0;
        start_run(6'd0, 6'd63, 16'd10, 16'd1);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (step_cnt >= 16'd2 && dp_u !== 4'd0) begin ok = 1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL midupd_timeout got 0 exp 1"); end
        RST = 1'b0;
        #1;
        checks++; if (dp_u !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midupd_abort got dp_u %h busy %0b exp 0 0", dp_u, busy);
        end
        checks++; if (step_cnt !== 16'd0 || episode_cnt !== 16'd0 || gamma_maxQ !== 24'd0) begin
            errors++; $display("FAIL midupd_clear got %0d/%0d/%h exp 0/0/0", step_cnt, episode_cnt, gamma_maxQ);
        end
        tick();
        RST = 1'b1;
        tick();
        epsilon = 8'd255;
        lf = 16'hACE1;
        start_run(6'd0, 6'd63, 16'd3, 16'd1);
        for (int s = 0; s < 3; s++) begin
            wait_req(ok);
            checks++; if (!ok) begin errors++; $display("FAIL explore_req_timeout step %0d got 0 exp 1", s); end
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            exp_a = (lf[7:0] < 8'd255) ? lf[9:8] : 2'd0;
            checks++; if (env_action !== exp_a) begin
                errors++; $display("FAIL explore_action step %0d got %0d exp %0d", s, env_action, exp_a);
            end
            for (int i = 0; i < 10 && env_req === 1'b1; i++) tick();
        end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL explore_done_timeout got 0 exp 1"); end
        tick();
    endtask

    initial begin
        RST = 1'b0; start = 1'b0;
        start_state = '0; goal_state = '0; gamma = '0; epsilon = '0;
        max_steps = '0; num_episodes = '0;
        clear_tabs();
        tick(); tick(); tick();
        test_reset();
        RST = 1'b1;
        tick();
        test_greedy_discount();
        test_saturation();
        test_episode_end();
        test_step_limit();
        test_stall();
        test_reset_mid_upd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
